// File: rtl/regfile_bist_pkg.sv
// Shared types for the register-file BIST: FSM state encoding and pattern codes.
package regfile_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PAT_ADDR = 2'd0,
    PAT_CHK  = 2'd1,
    PAT_ONES = 2'd2,
    PAT_INV  = 2'd3
  } pat_e;

endpackage

// File: rtl/regfile_bist_patgen.sv
// Combinational expected-data generator: maps (pattern, address) to the word the BIST writes/expects.
module regfile_bist_patgen
  import regfile_bist_pkg::*;
#(
  parameter int BW_DATA = 16,
  parameter int BW_ADDR = 4
) (
  input  pat_e                 i_pat,
  input  logic [BW_ADDR-1:0]   i_addr,
  output logic [BW_DATA-1:0]   o_exp
);

  always_comb begin
    o_exp = '0;
    case (i_pat)
      PAT_ADDR: o_exp = BW_DATA'(i_addr);
      PAT_CHK:  o_exp = i_addr[0] ? {(BW_DATA/2){2'b01}} : {(BW_DATA/2){2'b10}};
      PAT_ONES: o_exp = '1;
      PAT_INV:  o_exp = ~BW_DATA'(i_addr);
      default:  o_exp = '0;
    endcase
  end

endmodule

// File: rtl/regfile_bist.sv
// BIST initiator for the 1W/2R register file: write a pattern everywhere, read back on both ports, count mismatches.
// Optional REGFILE_BIST_FAILLOG_EN adds o_fail_addr/o_fail_data capturing the first mismatch of a run.
//
// state   | meaning
// IDLE    | waiting for i_start; rf outputs parked at 0
// WRITE   | writing exp(cnt) to entry cnt, DEPTH cycles
// READ    | port0 reads cnt, port1 reads DEPTH-1-cnt, both compared, DEPTH cycles
// DONE    | one-cycle o_done pulse, pass result already registered
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter int BW_DATA = 16,
  parameter int BW_ADDR = 4,
  parameter int BW_ERR  = 6
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic [1:0]         i_pat,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [BW_ERR-1:0]  o_err_cnt,
  output logic               o_rf_wr_en,
  output logic [BW_ADDR-1:0] o_rf_wr_addr,
  output logic [BW_DATA-1:0] o_rf_wr_data,
  output logic [BW_ADDR-1:0] o_rf_rd_addr0,
  output logic [BW_ADDR-1:0] o_rf_rd_addr1,
  input  logic [BW_DATA-1:0] i_rf_rd_data0,
  input  logic [BW_DATA-1:0] i_rf_rd_data1
`ifdef REGFILE_BIST_FAILLOG_EN
  ,
  output logic [BW_ADDR-1:0] o_fail_addr,
  output logic [BW_DATA-1:0] o_fail_data
`endif
);

  localparam logic [BW_ADDR-1:0] CNT_LAST = '1;
  localparam logic [BW_ERR:0]    ERR_MAX  = {1'b0, {BW_ERR{1'b1}}};

  state_e              state_q, state_d;
  logic [BW_ADDR-1:0]  cnt_q, cnt_d;
  pat_e                pat_q, pat_d;
  logic [BW_ERR-1:0]   err_q, err_d;
  logic                pass_q, pass_d;

  logic [BW_ADDR-1:0]  addr1;
  logic [BW_DATA-1:0]  exp0, exp1;
  logic                mism0, mism1;
  logic [BW_ERR:0]     err_sum;
  logic [BW_ERR-1:0]   err_sat;
  logic                start_acc;

  assign addr1 = CNT_LAST - cnt_q;

  regfile_bist_patgen #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) u_patgen0 (
    .i_pat  (pat_q),
    .i_addr (cnt_q),
    .o_exp  (exp0)
  );

  regfile_bist_patgen #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) u_patgen1 (
    .i_pat  (pat_q),
    .i_addr (addr1),
    .o_exp  (exp1)
  );

  assign mism0     = (i_rf_rd_data0 != exp0);
  assign mism1     = (i_rf_rd_data1 != exp1);
  assign err_sum   = {1'b0, err_q} + (BW_ERR+1)'(mism0) + (BW_ERR+1)'(mism1);
  assign err_sat   = (err_sum > ERR_MAX) ? ERR_MAX[BW_ERR-1:0] : err_sum[BW_ERR-1:0];
  assign start_acc = (state_q == ST_IDLE) && i_start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    err_d   = err_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
          pat_d   = pat_e'(i_pat);
          err_d   = '0;
          pass_d  = 1'b0;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_READ;
          cnt_d   = '0;
        end
      end
      ST_READ: begin
        cnt_d = cnt_q + 1'b1;
        err_d = err_sat;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          // include the final read pair in the verdict
          pass_d  = (err_sat == '0);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pat_q   <= PAT_ADDR;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  // Moore outputs only: reset forces wr_en low without waiting for a clock
  assign o_busy        = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign o_done        = (state_q == ST_DONE);
  assign o_pass        = pass_q;
  assign o_err_cnt     = err_q;
  assign o_rf_wr_en    = (state_q == ST_WRITE);
  assign o_rf_wr_addr  = o_rf_wr_en ? cnt_q : '0;
  assign o_rf_wr_data  = o_rf_wr_en ? exp0  : '0;
  assign o_rf_rd_addr0 = (state_q == ST_READ) ? cnt_q : '0;
  assign o_rf_rd_addr1 = (state_q == ST_READ) ? addr1 : '0;

`ifdef REGFILE_BIST_FAILLOG_EN
  logic               fail_seen_q, fail_seen_d;
  logic [BW_ADDR-1:0] fail_addr_q, fail_addr_d;
  logic [BW_DATA-1:0] fail_data_q, fail_data_d;

  always_comb begin
    fail_seen_d = fail_seen_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    if (start_acc) begin
      fail_seen_d = 1'b0;
      fail_addr_d = '0;
      fail_data_d = '0;
    end else if ((state_q == ST_READ) && !fail_seen_q && (mism0 || mism1)) begin
      fail_seen_d = 1'b1;
      fail_addr_d = mism0 ? cnt_q : addr1;
      fail_data_d = mism0 ? i_rf_rd_data0 : i_rf_rd_data1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      fail_seen_q <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      fail_seen_q <= fail_seen_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign o_fail_addr = fail_addr_q;
  assign o_fail_data = fail_data_q;
`else
  // without the fail log, mismatches only feed the error counter
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule
